// File: rtl/sap_ring_counter.sv
// sap_ring_counter
// T-state sequencer for the SAP controller-sequencer. Produces the one-hot
// timing states T1..T(STAGES) consumed by the control-word decoder, plus a
// binary index, a fetch flag, an end-of-cycle pulse and a registered halt flag.
// All state updates happen on the falling edge of CLK, mirroring the
// 74LS107-style stages of the original board.
//
// Ports:
//   CLK         in   system clock (state changes on falling edge)
//   CLR_bar     in   asynchronous reset, active-high despite the name
//   HLT         in   halt request, freezes sequencing
//   RESTART     in   early end-of-instruction return to T1
//   MANUAL      in   1 = single-step mode, 0 = free-run
//   STEP_BTN    in   raw push-button, asynchronous to CLK
//   T           out  one-hot T-state, T[0] = T1
//   T_IDX       out  0-based binary index of the active T-state
//   FETCH       out  high while T_IDX < FETCH_STAGES
//   CYCLE_DONE  out  one-cycle pulse on entry to T1 from another state
//   HALTED      out  registered copy of HLT
module sap_ring_counter #(
    parameter int STAGES       = 6,
    parameter int IDX_W        = 3,
    parameter int FETCH_STAGES = 3
) (
    input  logic              CLK,
    input  logic              CLR_bar,
    input  logic              HLT,
    input  logic              RESTART,
    input  logic              MANUAL,
    input  logic              STEP_BTN,
    output logic [STAGES-1:0] T,
    output logic [IDX_W-1:0]  T_IDX,
    output logic              FETCH,
    output logic              CYCLE_DONE,
    output logic              HALTED
);

    localparam logic [STAGES-1:0] T_FIRST = {{(STAGES-1){1'b0}}, 1'b1};
    localparam logic [STAGES-1:0] T_ZERO  = {STAGES{1'b0}};

    // Sequencer state
    logic [STAGES-1:0] r_t;
    logic [IDX_W-1:0]  r_idx;
    logic              r_fetch;
    logic              r_cycle_done;
    logic              r_halted;

    // Step path state
    logic [1:0]        r_sync;
    logic [2:0]        r_hist;
    logic              r_db;
    logic              r_db_d;

    logic              w_agree_hi;
    logic              w_agree_lo;
    logic              w_step_pulse;
    logic              w_adv;
    logic              w_onehot;
    logic [STAGES-1:0] w_t_next;
    logic [IDX_W-1:0]  w_idx_next;
    logic              w_cd_next;

    // The debounce window is the three stored samples plus the newest
    // synchronized one, so the level can change on the 4th agreeing sample
    // without an extra register stage of latency.
    assign w_agree_hi   = &{r_hist, r_sync[1]};
    assign w_agree_lo   = ~|{r_hist, r_sync[1]};
    assign w_step_pulse = r_db & ~r_db_d;
    assign w_adv        = ~HLT & (MANUAL ? w_step_pulse : 1'b1);

    // Zero or multiple hot bits (e.g. an upset) are both treated as corrupt.
    assign w_onehot = (r_t != T_ZERO) && ((r_t & (r_t - T_FIRST)) == T_ZERO);

    // Push-button synchronizer, agreement debounce and edge-detect history
    always_ff @(negedge CLK or posedge CLR_bar) begin
        if (CLR_bar) begin
            r_sync <= 2'b00;
            r_hist <= 3'b000;
            r_db   <= 1'b0;
            r_db_d <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], STEP_BTN};
            r_hist <= {r_hist[1:0], r_sync[1]};
            if (w_agree_hi) begin
                r_db <= 1'b1;
            end else if (w_agree_lo) begin
                r_db <= 1'b0;
            end else begin
                r_db <= r_db;
            end
            r_db_d <= r_db;
        end
    end

    // Next-state selection, index encoding and end-of-cycle detection
    always_comb begin
        w_t_next   = r_t;
        w_idx_next = {IDX_W{1'b0}};
        w_cd_next  = 1'b0;

        // Corruption recovery outranks halt so an upset cannot be frozen in.
        if (!w_onehot) begin
            w_t_next = T_FIRST;
        end else if (HLT) begin
            w_t_next = r_t;
        end else if (RESTART && w_adv) begin
            w_t_next = T_FIRST;
        end else if (w_adv) begin
            w_t_next = {r_t[STAGES-2:0], r_t[STAGES-1]};
        end else begin
            w_t_next = r_t;
        end

        for (int i = 0; i < STAGES; i++) begin
            if (w_t_next[i]) begin
                w_idx_next = IDX_W'(i);
            end else begin
                w_idx_next = w_idx_next;
            end
        end

        // Only a real T(k>1) -> T1 move counts; restart in T1 and recovery
        // from a corrupt pattern do not.
        w_cd_next = w_onehot && !r_t[0] && w_t_next[0];
    end

    // Sequencer registers, all updated together so T/T_IDX/FETCH agree
    always_ff @(negedge CLK or posedge CLR_bar) begin
        if (CLR_bar) begin
            r_t          <= T_FIRST;
            r_idx        <= {IDX_W{1'b0}};
            r_fetch      <= 1'b1;
            r_cycle_done <= 1'b0;
            r_halted     <= 1'b0;
        end else begin
            r_t          <= w_t_next;
            r_idx        <= w_idx_next;
            r_fetch      <= (int'(w_idx_next) < FETCH_STAGES);
            r_cycle_done <= w_cd_next;
            r_halted     <= HLT;
        end
    end

    assign T          = r_t;
    assign T_IDX      = r_idx;
    assign FETCH      = r_fetch;
    assign CYCLE_DONE = r_cycle_done;
    assign HALTED     = r_halted;

endmodule
